multicycle_ctrl: RTL and testbench

- Control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back over several cycles, reusing one ALU and one unified memory.
- Decodes the same opcode set as the single-cycle decoder and drives datapath mux selects and write enables state by state.
- Stalls on a memory ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, stalls on mem_ready_i, flags illegal opcodes and memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALU_op,
  output logic [1:0]       PCSource,
  output logic [1:0]       BranchType,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR  = 4'd2;
  localparam logic [3:0] S_MRD    = 4'd3;
  localparam logic [3:0] S_MWB    = 4'd4;
  localparam logic [3:0] S_MWR    = 4'd5;
  localparam logic [3:0] S_REXE   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_IEXE   = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BR     = 4'd10;
  localparam logic [3:0] S_JMP    = 4'd11;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire;
  logic              mem_wait;
  logic              expired;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_cnt_o = cnt_q;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_op      = 3'b000;
    PCSource    = 2'b00;
    BranchType  = 2'b00;
    illegal_o   = 1'b0;
    timeout_o   = 1'b0;

    mem_wait = ((state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR)) && !mem_ready_i;
    expired  = mem_wait && (wait_q == WAIT_W'(TIMEOUT - 1));

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALU_op  = 3'b010;
        if (mem_ready_i) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode is decoded
        ALUSrcB = 2'b11;
        ALU_op  = 3'b010;
        case (instr_op_i)
          6'd35, 6'd43:                 state_d = S_MADDR;
          6'd0:                         state_d = S_REXE;
          6'd8, 6'd11, 6'd13, 6'd15:    state_d = S_IEXE;
          6'd4, 6'd5, 6'd6, 6'd7:       state_d = S_BR;
          6'd2, 6'd3:                   state_d = S_JMP;
          default: begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALU_op  = 3'b010;
        if (instr_op_i == 6'd35)      state_d = S_MRD;
        else if (instr_op_i == 6'd43) state_d = S_MWR;
        else                          state_d = S_FETCH;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready_i) state_d = S_MWB;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_REXE: begin
        ALUSrcA = 1'b1;
        ALU_op  = 3'b111;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_IEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (instr_op_i)
          6'd11:   ALU_op = 3'b100;
          6'd13:   ALU_op = 3'b001;
          6'd15:   ALU_op = 3'b110;
          default: ALU_op = 3'b010;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALU_op      = 3'b011;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchType  = instr_op_i[1:0];
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        // jal links the already-incremented PC into $31
        if (instr_op_i == 6'd3) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          ALU_op   = 3'b010;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // A ready in the last allowed cycle completes normally; only a still-low ready aborts
    if (expired) begin
      state_d   = S_FETCH;
      MemWrite  = 1'b0;
      timeout_o = 1'b1;
      retire    = 1'b0;
    end

    if ((state_d != state_q) || expired) wait_d = '0;
    else if (mem_wait)                   wait_d = wait_q + WAIT_W'(1);
    else                                 wait_d = wait_q;

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    if (!rst_i) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALU_op      = 3'b000;
      PCSource    = 2'b00;
      BranchType  = 2'b00;
      illegal_o   = 1'b0;
      timeout_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random-stimulus bench for multicycle_ctrl: a per-instruction phase-list model
// predicts every control output and the retired count (32-bit and 4-bit instances).
module tb_multicycle_ctrl;

  localparam int unsigned TIMEOUT = 16;

  typedef enum int {P_FETCH, P_DEC, P_MADDR, P_MRD, P_MWB, P_MWR,
                    P_REXE, P_RWB, P_IEXE, P_IWB, P_BR, P_JMP} phase_e;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  instr_op_i;
  logic        mem_ready_i;
  wire  [21:0] ctrl_a, ctrl_b;
  wire  [31:0] cnt_a;
  wire  [3:0]  cnt_b;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.CNT_W(32), .TIMEOUT(TIMEOUT)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite(ctrl_a[21]), .PCWriteCond(ctrl_a[20]), .IorD(ctrl_a[19]), .MemRead(ctrl_a[18]),
    .MemWrite(ctrl_a[17]), .IRWrite(ctrl_a[16]), .MemToReg(ctrl_a[15]), .RegWrite(ctrl_a[14]),
    .RegDst(ctrl_a[13:12]), .ALUSrcA(ctrl_a[11]), .ALUSrcB(ctrl_a[10:9]), .ALU_op(ctrl_a[8:6]),
    .PCSource(ctrl_a[5:4]), .BranchType(ctrl_a[3:2]), .illegal_o(ctrl_a[1]), .timeout_o(ctrl_a[0]),
    .instr_cnt_o(cnt_a)
  );

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT(TIMEOUT)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite(ctrl_b[21]), .PCWriteCond(ctrl_b[20]), .IorD(ctrl_b[19]), .MemRead(ctrl_b[18]),
    .MemWrite(ctrl_b[17]), .IRWrite(ctrl_b[16]), .MemToReg(ctrl_b[15]), .RegWrite(ctrl_b[14]),
    .RegDst(ctrl_b[13:12]), .ALUSrcA(ctrl_b[11]), .ALUSrcB(ctrl_b[10:9]), .ALU_op(ctrl_b[8:6]),
    .PCSource(ctrl_b[5:4]), .BranchType(ctrl_b[3:2]), .illegal_o(ctrl_b[1]), .timeout_o(ctrl_b[0]),
    .instr_cnt_o(cnt_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model of the in-flight instruction: its phase list and progress through it
  phase_e      path[$];
  int          idx;
  int          wcnt;
  int          mode;
  logic [5:0]  m_op;
  logic [31:0] m_cnt;
  int          dir_op[$];
  int          dir_mode[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                      6'd8, 6'd11, 6'd13, 6'd15, 6'd35, 6'd43};
  endfunction

  function automatic logic [21:0] exp_ctrl(input phase_e ph, input logic [5:0] op,
                                           input logic rdy, input logic tmo);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, srca, ill;
    logic [1:0] rdst, srcb, pcs, bt;
    logic [2:0] alu;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, srca, ill} = '0;
    {rdst, srcb, pcs, bt, alu} = '0;
    case (ph)
      P_FETCH: begin mrd = 1; srcb = 2'b01; alu = 3'b010; if (rdy) begin irw = 1; pcw = 1; end end
      P_DEC:   begin srcb = 2'b11; alu = 3'b010; ill = !is_legal(op); end
      P_MADDR: begin srca = 1; srcb = 2'b10; alu = 3'b010; end
      P_MRD:   begin mrd = 1; iord = 1; end
      P_MWB:   begin rw = 1; m2r = 1; end
      P_MWR:   begin mwr = !tmo; iord = 1; end
      P_REXE:  begin srca = 1; alu = 3'b111; end
      P_RWB:   begin rw = 1; rdst = 2'b01; end
      P_IEXE:  begin
        srca = 1; srcb = 2'b10;
        alu = (op == 6'd8) ? 3'b010 : (op == 6'd11) ? 3'b100 : (op == 6'd13) ? 3'b001 : 3'b110;
      end
      P_IWB:   rw = 1;
      P_BR:    begin srca = 1; alu = 3'b011; pcwc = 1; pcs = 2'b01; bt = op[1:0]; end
      P_JMP:   begin
        pcw = 1; pcs = 2'b10;
        if (op == 6'd3) begin rw = 1; rdst = 2'b10; alu = 3'b010; end
      end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, alu, pcs, bt, ill, tmo};
  endfunction

  task automatic new_instr();
    int r;
    if (dir_op.size() > 0) begin
      m_op = 6'(dir_op.pop_front());
      mode = dir_mode.pop_front();
    end else begin
      r = int'($urandom_range(0, 99));
      if (r < 85) begin
        case ($urandom_range(0, 12))
          0: m_op = 6'd0;   1: m_op = 6'd2;   2: m_op = 6'd3;   3: m_op = 6'd4;
          4: m_op = 6'd5;   5: m_op = 6'd6;   6: m_op = 6'd7;   7: m_op = 6'd8;
          8: m_op = 6'd11;  9: m_op = 6'd13;  10: m_op = 6'd15; 11: m_op = 6'd35;
          default: m_op = 6'd43;
        endcase
      end else begin
        m_op = 6'($urandom);
      end
      r = int'($urandom_range(0, 99));
      mode = (r < 40) ? 0 : (r < 85) ? 1 : (r < 95) ? 2 : 3;
    end
    path.delete();
    path.push_back(P_FETCH);
    path.push_back(P_DEC);
    if (m_op == 6'd35) begin path.push_back(P_MADDR); path.push_back(P_MRD); path.push_back(P_MWB); end
    else if (m_op == 6'd43) begin path.push_back(P_MADDR); path.push_back(P_MWR); end
    else if (m_op == 6'd0) begin path.push_back(P_REXE); path.push_back(P_RWB); end
    else if (m_op inside {6'd8, 6'd11, 6'd13, 6'd15}) begin path.push_back(P_IEXE); path.push_back(P_IWB); end
    else if (m_op inside {6'd4, 6'd5, 6'd6, 6'd7}) path.push_back(P_BR);
    else if (m_op inside {6'd2, 6'd3}) path.push_back(P_JMP);
    idx  = 0;
    wcnt = 0;
  endtask

  // One clock: drive at the falling edge, check mid-low-phase, advance the model
  task automatic step();
    phase_e ph;
    logic   rdy, memph, tmo;
    @(negedge clk_i);
    ph = path[idx];
    instr_op_i = m_op;
    case (mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'($urandom_range(0, 1));
      2:       rdy = (ph == P_FETCH);
      default: rdy = 1'b0;
    endcase
    mem_ready_i = rdy;
    #2;
    memph = (ph == P_FETCH) || (ph == P_MRD) || (ph == P_MWR);
    tmo   = memph && !rdy && (wcnt == int'(TIMEOUT) - 1);
    check_eq("ctrl",  32'(ctrl_a), 32'(exp_ctrl(ph, m_op, rdy, tmo)));
    check_eq("ctrl4", 32'(ctrl_b), 32'(exp_ctrl(ph, m_op, rdy, tmo)));
    check_eq("cnt",   cnt_a, m_cnt);
    check_eq("cnt4",  32'(cnt_b), m_cnt & 32'hF);
    if (tmo) begin
      new_instr();
    end else if (memph && !rdy) begin
      wcnt++;
    end else begin
      wcnt = 0;
      idx++;
      if (idx == path.size()) begin
        if (is_legal(m_op)) m_cnt = m_cnt + 32'd1;
        new_instr();
      end
    end
  endtask

  initial begin
    logic reached;
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    instr_op_i  = 6'd0;
    @(posedge clk_i);
    #1;
    check_eq("rst_ctrl",  32'(ctrl_a), 32'd0);
    check_eq("rst_ctrl4", 32'(ctrl_b), 32'd0);
    check_eq("rst_cnt",   cnt_a, 32'd0);
    check_eq("rst_cnt4",  32'(cnt_b), 32'd0);
    rst_i = 1'b1;

    m_cnt    = '0;
    dir_op   = '{0, 35, 4, 5, 3, 63, 43, 35};
    dir_mode = '{0, 1, 0, 0, 0, 0, 2, 2};
    new_instr();
    for (int i = 0; i < 3000; i++) step();

    // Reset asserted while a load is waiting in its memory-read phase
    dir_op.push_back(35);
    dir_mode.push_back(2);
    reached = 1'b0;
    for (int i = 0; i < 600 && !reached; i++) begin
      if (dir_op.size() == 0 && path[idx] == P_MRD) reached = 1'b1;
      else step();
    end
    check_eq("reach_mrd", 32'(reached), 32'd1);
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    #1 rst_i = 1'b0;
    #1;
    check_eq("midrst_ctrl",  32'(ctrl_a), 32'd0);
    check_eq("midrst_ctrl4", 32'(ctrl_b), 32'd0);
    check_eq("midrst_cnt",   cnt_a, 32'd0);
    check_eq("midrst_cnt4",  32'(cnt_b), 32'd0);
    @(posedge clk_i);
    #1;
    check_eq("hold_ctrl", 32'(ctrl_a), 32'd0);
    rst_i = 1'b1;
    m_cnt = '0;
    new_instr();
    for (int i = 0; i < 400; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
